// File: rtl/bcd_seq_multiplier_if.sv
// ---------------------------------------------------------------------------
// bcd_seq_multiplier_if
// Start/done handshake bundle for the sequential BCD multiplier.
//   start   : request, master -> slave
//   a, b    : packed-BCD operands (4*DIGITS bits), master -> slave
//   product : packed-BCD result (8*DIGITS bits), slave -> master
//   busy    : computation in progress, slave -> master
//   done    : one-cycle result-valid pulse, slave -> master
//   error   : an operand held a nibble above 9, slave -> master
// ---------------------------------------------------------------------------
interface bcd_seq_multiplier_if #(parameter int DIGITS = 4);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic [8*DIGITS-1:0]   product;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (output start, a, b, input product, busy, done, error);
  modport slave  (input start, a, b, output product, busy, done, error);
endinterface

// File: rtl/bcd_seq_multiplier.sv
// ---------------------------------------------------------------------------
// bcd_seq_multiplier
// Digit-serial shift-and-add multiplier for DIGITS-digit packed-BCD operands.
// Walks the multiplier from its most significant digit: each digit costs one
// SHIFT cycle (accumulator x10) plus one ADD cycle per unit of the digit.
// Operands containing a non-BCD nibble are rejected with error=1, product=0.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_seq_multiplier_if (start/a/b in,
//           product/busy/done/error out)
// ---------------------------------------------------------------------------
module bcd_seq_multiplier #(
  parameter int DIGITS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  bcd_seq_multiplier_if.slave  bus
);

  localparam int OPW  = 4 * DIGITS;
  localparam int PW   = 8 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, ADD, DONE} state_t;

  state_t            state_q, state_d;
  logic [OPW-1:0]    a_q, a_d;
  logic [OPW-1:0]    b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     product_q, product_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              error_q, error_d;
  logic [3:0]        digit;
  logic [PW-1:0]     accPlusA;

  // Ripple decimal adder: nibble sums above 9 are corrected by +6 and carry.
  function automatic logic [PW-1:0] bcdAdd(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW-1:0] r;
    logic [4:0]    s;
    logic          c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 2 * DIGITS; i++) begin
      s = {1'b0, x[i*4 +: 4]} + {1'b0, y[i*4 +: 4]} + {4'b0000, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = s[3:0];
    end
    return r;
  endfunction

  function automatic logic hasBadNibble(input logic [OPW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Multiplier digit currently being consumed.
  always_comb begin
    digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) digit = b_q[i*4 +: 4];
    end
  end

  assign accPlusA = bcdAdd(acc_q, {{(PW-OPW){1'b0}}, a_q});

  // Next-state logic: accept in IDLE/DONE, then walk the multiplier digits.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    error_d   = error_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          acc_d = '0;
          idx_d = IDXW'(DIGITS - 1);
          cnt_d = '0;
          if (hasBadNibble(bus.a) || hasBadNibble(bus.b)) begin
            // Rejected job goes straight to DONE so done pulses next cycle.
            product_d = '0;
            error_d   = 1'b1;
            state_d   = DONE;
          end else begin
            error_d = 1'b0;
            state_d = SHIFT;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = acc_q << 4;
        cnt_d = digit;
        if (digit != 4'd0) begin
          state_d = ADD;
        end else if (idx_q == '0) begin
          product_d = acc_q << 4;
          state_d   = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ADD: begin
        acc_d = accPlusA;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (idx_q == '0) begin
            product_d = accPlusA;
            state_d   = DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = SHIFT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      error_q   <= error_d;
    end
  end

  assign bus.product = product_q;
  assign bus.error   = error_q;
  assign bus.busy    = (state_q == SHIFT) || (state_q == ADD);
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_bcd_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_bcd_seq_multiplier
// Drives a DIGITS=1 and a DIGITS=4 multiplier; expected results come from a
// decimal reference model and are queued when a job is started, then popped
// and compared when done is observed.
// ---------------------------------------------------------------------------
module tb_bcd_seq_multiplier;

  typedef struct {
    logic [31:0] prod;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFails  = 0;
  exp_t sb4[$];
  exp_t sb1[$];

  bcd_seq_multiplier_if #(.DIGITS(4)) bus4 ();
  bcd_seq_multiplier_if #(.DIGITS(1)) bus1 ();

  bcd_seq_multiplier #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  bcd_seq_multiplier #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case something never returns.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Decimal reference: digit-wise value, integer product, back to BCD.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int digits);
    exp_t       e;
    int         av, bv, p, s;
    logic       bad;
    logic [3:0] na, nb;
    av = 0; bv = 0; s = 0; bad = 1'b0;
    for (int i = digits - 1; i >= 0; i--) begin
      na = a[i*4 +: 4];
      nb = b[i*4 +: 4];
      if (na > 4'd9 || nb > 4'd9) bad = 1'b1;
      av = av * 10 + int'(na);
      bv = bv * 10 + int'(nb);
      s  = s + int'(nb);
    end
    e.prod = '0;
    if (bad) begin
      e.err = 1'b1;
      e.lat = 0;
    end else begin
      e.err = 1'b0;
      e.lat = digits + s;
      p = av * bv;
      for (int i = 0; i < 2 * digits; i++) begin
        e.prod[i*4 +: 4] = 4'(p % 10);
        p = p / 10;
      end
    end
    return e;
  endfunction

  // Start a DIGITS=4 job from the current negedge; returns one negedge later.
  task automatic start4(input logic [15:0] a, input logic [15:0] b);
    bus4.start = 1'b1;
    bus4.a     = a;
    bus4.b     = b;
    sb4.push_back(model({16'h0, a}, {16'h0, b}, 4));
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // Wait for done, counting busy cycles; optionally disturb start/a/b mid-job.
  task automatic wait4(input int disturbAt, output int busyCycles, output bit gotDone,
                       output bit prodMoved);
    logic [31:0] prodSeen;
    busyCycles = 0;
    gotDone    = 1'b0;
    prodMoved  = 1'b0;
    prodSeen   = bus4.product;
    for (int i = 0; i < 200; i++) begin
      if (bus4.done) begin
        gotDone = 1'b1;
        break;
      end
      if (bus4.busy) busyCycles++;
      if (bus4.product !== prodSeen) prodMoved = 1'b1;
      if (i == disturbAt) begin
        bus4.start = 1'b1;
        bus4.a     = 16'h1111;
        bus4.b     = 16'h2222;
      end else if (i == disturbAt + 1) begin
        bus4.start = 1'b0;
        bus4.a     = 16'h3333;
        bus4.b     = 16'h4444;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
    repeat (2) @(negedge clk);
    nChecks += 2;
    if ({bus4.product, bus4.busy, bus4.done, bus4.error} !== 35'h0) begin
      nFails++;
      $display("[TB] FAIL reset4: outputs %h, expected 0",
               {bus4.product, bus4.busy, bus4.done, bus4.error});
    end
    if ({bus1.product, bus1.busy, bus1.done, bus1.error} !== 11'h0) begin
      nFails++;
      $display("[TB] FAIL reset1: outputs %h, expected 0",
               {bus1.product, bus1.busy, bus1.done, bus1.error});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exhaustive_d1();
    exp_t e;
    int   lat;
    bit   got;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.a     = 4'(ai);
        bus1.b     = 4'(bi);
        sb1.push_back(model({28'h0, 4'(ai)}, {28'h0, 4'(bi)}, 1));
        @(negedge clk);
        bus1.start = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
          if (bus1.done) begin
            got = 1'b1;
            break;
          end
          if (bus1.busy) lat++;
          @(negedge clk);
        end
        e = sb1.pop_front();
        nChecks += 4;
        if (!got) begin
          nFails++;
          $display("[TB] FAIL d1_timeout a=%0d b=%0d: no done seen, done required", ai, bi);
        end
        if (bus1.product !== e.prod[7:0]) begin
          nFails++;
          $display("[TB] FAIL d1_product a=%0d b=%0d: got %h, expected %h", ai, bi, bus1.product, e.prod[7:0]);
        end
        if (bus1.error !== e.err) begin
          nFails++;
          $display("[TB] FAIL d1_error a=%0d b=%0d: got %b, expected %b", ai, bi, bus1.error, e.err);
        end
        if (lat != e.lat) begin
          nFails++;
          $display("[TB] FAIL d1_latency a=%0d b=%0d: got %0d, expected %0d", ai, bi, lat, e.lat);
        end
      end
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    bit   got, moved;
    @(negedge clk);
    start4(16'h1234, 16'h5678);
    wait4(-10, lat, got, moved);
    e = sb4.pop_front();
    nChecks += 6;
    if (!got) begin nFails++; $display("[TB] FAIL basic_timeout: no done seen, done required"); end
    if (bus4.product !== e.prod) begin
      nFails++; $display("[TB] FAIL basic_product: got %h, expected %h", bus4.product, e.prod);
    end
    if (bus4.error !== e.err) begin
      nFails++; $display("[TB] FAIL basic_error: got %b, expected %b", bus4.error, e.err);
    end
    if (lat != e.lat) begin
      nFails++; $display("[TB] FAIL basic_busy_cycles: got %0d, expected %0d", lat, e.lat);
    end
    if (bus4.busy !== 1'b0) begin
      nFails++; $display("[TB] FAIL basic_busy_with_done: busy=%b, expected 0", bus4.busy);
    end
    if (moved) begin
      nFails++; $display("[TB] FAIL basic_product_hold: product moved while busy, expected stable");
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   got, moved;
    @(negedge clk);
    start4(16'h9999, 16'h9999);
    wait4(-10, lat, got, moved);
    e = sb4.pop_front();
    nChecks += 3;
    if (!got) begin nFails++; $display("[TB] FAIL b2b_first_timeout: no done seen, done required"); end
    if (bus4.product !== e.prod) begin
      nFails++; $display("[TB] FAIL b2b_first_product: got %h, expected %h", bus4.product, e.prod);
    end
    if (lat != e.lat) begin
      nFails++; $display("[TB] FAIL b2b_first_latency: got %0d, expected %0d", lat, e.lat);
    end
    // Issue the next job while done is still high.
    start4(16'h0000, 16'h0000);
    wait4(-10, lat, got, moved);
    e = sb4.pop_front();
    nChecks += 4;
    if (!got) begin nFails++; $display("[TB] FAIL b2b_second_timeout: no done seen, done required"); end
    if (bus4.product !== e.prod) begin
      nFails++; $display("[TB] FAIL b2b_second_product: got %h, expected %h", bus4.product, e.prod);
    end
    if (bus4.error !== e.err) begin
      nFails++; $display("[TB] FAIL b2b_second_error: got %b, expected %b", bus4.error, e.err);
    end
    if (lat != e.lat) begin
      nFails++; $display("[TB] FAIL b2b_second_latency: got %0d, expected %0d", lat, e.lat);
    end
  endtask

  task automatic test_invalid();
    exp_t e;
    int   lat;
    bit   got, moved;
    @(negedge clk);
    start4(16'h12A4, 16'h0001);
    wait4(-10, lat, got, moved);
    e = sb4.pop_front();
    nChecks += 4;
    if (!got) begin nFails++; $display("[TB] FAIL invalid_timeout: no done seen, done required"); end
    if (bus4.product !== e.prod) begin
      nFails++; $display("[TB] FAIL invalid_product: got %h, expected %h", bus4.product, e.prod);
    end
    if (bus4.error !== e.err) begin
      nFails++; $display("[TB] FAIL invalid_error: got %b, expected %b", bus4.error, e.err);
    end
    if (lat != e.lat) begin
      nFails++; $display("[TB] FAIL invalid_latency: got %0d, expected %0d", lat, e.lat);
    end
    @(negedge clk);
    start4(16'h0002, 16'h0003);
    wait4(-10, lat, got, moved);
    e = sb4.pop_front();
    nChecks += 4;
    if (!got) begin nFails++; $display("[TB] FAIL recover_timeout: no done seen, done required"); end
    if (bus4.product !== e.prod) begin
      nFails++; $display("[TB] FAIL recover_product: got %h, expected %h", bus4.product, e.prod);
    end
    if (bus4.error !== e.err) begin
      nFails++; $display("[TB] FAIL recover_error: got %b, expected %b", bus4.error, e.err);
    end
    if (lat != e.lat) begin
      nFails++; $display("[TB] FAIL recover_latency: got %0d, expected %0d", lat, e.lat);
    end
  endtask

  task automatic test_ignored_start();
    exp_t e;
    int   lat;
    bit   got, moved;
    @(negedge clk);
    start4(16'h9999, 16'h9999);
    // Index 4 is the negedge before E0+5.
    wait4(4, lat, got, moved);
    e = sb4.pop_front();
    nChecks += 4;
    if (!got) begin nFails++; $display("[TB] FAIL ignore_timeout: no done seen, done required"); end
    if (bus4.product !== e.prod) begin
      nFails++; $display("[TB] FAIL ignore_product: got %h, expected %h", bus4.product, e.prod);
    end
    if (lat != e.lat) begin
      nFails++; $display("[TB] FAIL ignore_latency: got %0d, expected %0d", lat, e.lat);
    end
    if (moved) begin
      nFails++; $display("[TB] FAIL ignore_product_hold: product moved while busy, expected stable");
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   lat;
    bit   got, moved, sawDone;
    @(negedge clk);
    start4(16'h1234, 16'h5678);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    void'(sb4.pop_back());
    nChecks += 4;
    if (bus4.product !== 32'h0) begin
      nFails++; $display("[TB] FAIL abort_product: got %h, expected 0", bus4.product);
    end
    if (bus4.busy !== 1'b0) begin
      nFails++; $display("[TB] FAIL abort_busy: got %b, expected 0", bus4.busy);
    end
    if (bus4.done !== 1'b0) begin
      nFails++; $display("[TB] FAIL abort_done: got %b, expected 0", bus4.done);
    end
    if (bus4.error !== 1'b0) begin
      nFails++; $display("[TB] FAIL abort_error: got %b, expected 0", bus4.error);
    end
    sawDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus4.done !== 1'b0) sawDone = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) sawDone = 1'b1;
    end
    nChecks++;
    if (sawDone) begin
      nFails++; $display("[TB] FAIL abort_no_done: activity after reset, expected idle");
    end
    start4(16'h1234, 16'h5678);
    wait4(-10, lat, got, moved);
    e = sb4.pop_front();
    nChecks += 4;
    if (!got) begin nFails++; $display("[TB] FAIL rerun_timeout: no done seen, done required"); end
    if (bus4.product !== e.prod) begin
      nFails++; $display("[TB] FAIL rerun_product: got %h, expected %h", bus4.product, e.prod);
    end
    if (bus4.error !== e.err) begin
      nFails++; $display("[TB] FAIL rerun_error: got %b, expected %b", bus4.error, e.err);
    end
    if (lat != e.lat) begin
      nFails++; $display("[TB] FAIL rerun_latency: got %0d, expected %0d", lat, e.lat);
    end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] starting bcd_seq_multiplier bench");
    test_reset();
    test_exhaustive_d1();
    test_basic();
    test_back_to_back();
    test_invalid();
    test_ignored_start();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/bcd_seq_multiplier.md
# bcd_seq_multiplier

Sequential, parametrised BCD multiplier. Multiplies two unsigned DIGITS-digit packed-BCD operands into a 2·DIGITS-digit packed-BCD product using digit-serial shift-and-add. This is the multi-digit successor of the single-digit combinational BCD multiplier. It sits in the Ej5 arithmetic datapath behind a start/done handshake and flags non-BCD operand nibbles instead of producing garbage.

## Interface

- DIGITS, 4, number of BCD digits per operand (≥1); operand width 4·DIGITS, product width 8·DIGITS
- Clock is `clk`, single clock domain; reset is `rst_n`, asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  4·DIGITS  multiplicand, packed BCD, MS nibble = MS digit
- b  in  4·DIGITS  multiplier, packed BCD
- product  out  8·DIGITS  packed-BCD result, held until next accepted start
- busy  out  1  high while computing (SHIFT/ADD)
- done  out  1  one-cycle pulse, product/error valid
- error  out  1  operand contained a nibble > 9; held with product

## Operation

- States: IDLE, SHIFT, ADD, DONE.
- Accept: start=1 in IDLE or DONE. a and b are captured into internal registers; later changes on a/b are ignored. start in SHIFT/ADD is ignored.
- Validity check at accept: if any nibble of a or b is > 9, go directly to DONE with product=0, error=1.
- Otherwise: acc (2·DIGITS digits) = 0, idx = DIGITS-1, error=0, and go to SHIFT.
- SHIFT: acc <= acc shifted left one nibble (×10); cnt <= b digit[idx].
  - digit ≠ 0 → ADD.
  - digit = 0 and idx = 0 → DONE.
  - digit = 0 and idx > 0 → idx--, stay in SHIFT.
- ADD: acc <= acc + a (a zero-extended to 2·DIGITS digits); cnt--.
  - When this is the last add (cnt = 1): idx = 0 → DONE; else idx--, → SHIFT.
- BCD add: ripple per digit. Binary nibble sum plus carry-in; if the sum > 9, add 6 and set carry-out. The final carry is provably 0 because the product is < 10^(2·DIGITS).
- Entry to DONE: product <= acc (or 0 on error), done=1.
- DONE → IDLE on the next edge unless start=1, which is accepted immediately (back-to-back).
- Reset values: state IDLE, product=0, busy=0, done=0, error=0, all internal registers 0.
- Reset mid-operation aborts immediately. No done pulse follows.

## Timing

- E0 = the accepting edge. Let S = sum of the decimal digits of b.
- Valid operands: SHIFT/ADD occupy exactly DIGITS + S cycles. The edge E0+DIGITS+S enters DONE. done is high for the single cycle after that edge.
- Invalid operands: DONE is entered at E0 (done high in the cycle after E0).
- Latency range: DIGITS to 10·DIGITS cycles.
- busy is high from E0 until the edge that enters DONE, and low during DONE and IDLE. busy and done are never high together.
- product changes only on entry to DONE.

## Test plan

- DIGITS=1, exhaustive sweep: all 16×16 a,b pairs, each started from IDLE → for the 100 valid pairs, product = the decimal product in BCD and error=0; for the other 156 pairs, error=1, product=0x00, done one cycle after accept.
- DIGITS=4, a=0x1234, b=0x5678 → product=0x07006652, error=0, done in the cycle after E0+30, busy high for exactly 30 cycles.
- DIGITS=4, a=0x9999, b=0x9999 → product=0x99980001 after 40 cycles. Then a=0x0000, b=0x0000 started in DONE (back-to-back) → product=0x00000000 after 4 cycles.
- DIGITS=4, start with a=0x12A4, b=0x0001 → error=1, product=0, done in the cycle after E0. A following valid job (0x0002×0x0003) clears error and gives product 0x00000006.
- DIGITS=4, 0x9999×0x9999 started, then start pulsed with different operands at E0+5 and a/b changed → ignored; result is still 0x99980001.
- Assert rst_n=0 at E0+10 of 0x1234×0x5678 → all outputs 0 immediately (asynchronous), state IDLE, no done pulse. After release, the same job completes correctly with 30-cycle latency.
